ps2_paddle_rx: RTL and testbench

//  PS/2 keyboard receiver and make/break decoder driving the four paddle

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_frame_rx.sv | 172 +++++++++++++++++
 rtl/ps2_paddle_rx.sv | 107 ++++++++++
 tb/tb_ps2_paddle_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared constants and helpers for the PS/2 paddle receiver.
//   - PS/2 set-2 scan codes used by the pong controls and the prefix bytes.
//   - Frame FSM state encodings (plain localparams so older tools and the
//     legacy parts of the codebase can use them unchanged).
//   - Key identifiers and a scan-code-to-key lookup used by the decoder.
// -----------------------------------------------------------------------------
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK    = 8'hF0;  // break (key release) prefix

  // Game keys
  localparam logic [7:0] SC_A      = 8'h1C;  // player 1 left
  localparam logic [7:0] SC_D      = 8'h23;  // player 1 right
  localparam logic [7:0] SC_LARROW = 8'h6B;  // player 2 left  (needs E0)
  localparam logic [7:0] SC_RARROW = 8'h74;  // player 2 right (needs E0)

  // Frame FSM states. The start bit is recognised from IDLE, so it has no
  // state of its own.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Key register bit positions
  typedef enum logic [1:0] {
    KEY_LEFT1  = 2'd0,
    KEY_RIGHT1 = 2'd1,
    KEY_LEFT2  = 2'd2,
    KEY_RIGHT2 = 2'd3
  } key_e;

  typedef struct packed {
    logic hit;   // byte (with its E0 state) is one of the four game keys
    key_e key;   // which key, valid only when hit=1
  } key_map_t;

  // Look up a scan byte together with the pending E0 flag. Keypad 4/6 send
  // 6B/74 without E0 and must not move player 2, and E0-prefixed 1C/23 are
  // not game keys, so the extension flag is part of the match.
  function automatic key_map_t map_key(input logic ext, input logic [7:0] sc);
    key_map_t m;
    m.hit = 1'b0;
    m.key = KEY_LEFT1;
    case ({ext, sc})
      {1'b0, SC_A}:      begin m.hit = 1'b1; m.key = KEY_LEFT1;  end
      {1'b0, SC_D}:      begin m.hit = 1'b1; m.key = KEY_RIGHT1; end
      {1'b1, SC_LARROW}: begin m.hit = 1'b1; m.key = KEY_LEFT2;  end
      {1'b1, SC_RARROW}: begin m.hit = 1'b1; m.key = KEY_RIGHT2; end
      default:           begin m.hit = 1'b0; m.key = KEY_LEFT1;  end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// -----------------------------------------------------------------------------
// ps2_frame_rx
// Deserialises PS/2 device-to-host frames (start, 8 data LSB first, parity,
// stop) sampled on falling edges of the synchronised PS/2 clock.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on ps2_clk / ps2_data (2..3)
//   TIMEOUT_CYC  mclk cycles without a ps2_clk fall mid-frame before abort
//
// Ports
//   mclk      in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   ps2_clk   in   PS/2 clock, asynchronous, idle high
//   ps2_data  in   PS/2 data, asynchronous, idle high
//   rx_byte   out  last accepted byte (held between frames)
//   rx_valid  out  one-cycle strobe, rx_byte updated
//   rx_err    out  one-cycle strobe, frame rejected or timed out
//
// Build option
//   PS2_PARITY_CHECK_EN  when defined, odd parity over data+parity is
//                        required; otherwise the parity bit is ignored.
// -----------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  // NOTE: the synchroniser flops reset to 1 (the bus idle level), not 0;
  // resetting them low would make the first cycles after reset look like a
  // falling PS/2 clock with a start bit on data.
  always_ff @(posedge mclk) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // ---------------------------------------------------------------------------
  // Frame FSM state
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] tmr;
  logic          tmr_hit;
  logic          parity_ok;

  // The timer only matters while a frame is in flight; a fall always restarts
  // it, so a fall on the expiry cycle wins and the frame continues.
  assign tmr_hit = (state != ST_IDLE) && !fall && (tmr == TMR_LAST);

  always_ff @(posedge mclk) begin
    if (!rst) begin
      tmr <= '0;
    end else if (fall || state == ST_IDLE || tmr_hit) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Running XOR over the 8 data bits and the parity bit; a valid frame has
  // an odd number of ones, i.e. the accumulator ends at 1.
  logic par_acc;

  always_ff @(posedge mclk) begin
    if (!rst) begin
      par_acc <= 1'b0;
    end else if (fall) begin
      if (state == ST_IDLE) begin
        par_acc <= 1'b0;
      end else if (state == ST_DATA || state == ST_PARITY) begin
        par_acc <= par_acc ^ data_s;
      end
    end
  end

  assign parity_ok = par_acc;
`else
  // Parity bit is clocked through the PARITY state but its value is unused.
  assign parity_ok = 1'b1;
`endif

  // NOTE: every register in a clocked block is assigned with <=, so all of
  // them update together from pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      // Strobes default low and are raised for exactly one cycle.
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      if (tmr_hit) begin
        // Keyboard went quiet mid-frame: drop the partial byte.
        state  <= ST_IDLE;
        rx_err <= 1'b1;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            // A fall with data high is not a start bit; stay idle.
            if (!data_s) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {data_s, shift[7:1]};  // LSB arrives first
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (data_s && parity_ok) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err   <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_paddle_rx.sv
// -----------------------------------------------------------------------------
// ps2_paddle_rx
// PS/2 keyboard receiver and make/break decoder for the pong paddles. The
// frame receiver delivers scan bytes; this level tracks the E0 (extended)
// and F0 (break) prefixes and holds each paddle control high while its key
// is down.
//
// Parameters
//   SYNC_STAGES  synchroniser depth on ps2_clk / ps2_data (2..3)
//   TIMEOUT_CYC  mclk cycles with no ps2_clk fall mid-frame before abort
//
// Ports
//   mclk        in   system clock, rising edge
//   rst         in   synchronous active-low reset
//   ps2_clk     in   PS/2 clock from keyboard, asynchronous, idle high
//   ps2_data    in   PS/2 data from keyboard, asynchronous, idle high
//   to_left1    out  player 1 left held  (A, 1C)
//   to_right1   out  player 1 right held (D, 23)
//   to_left2    out  player 2 left held  (E0 6B, left arrow)
//   to_right2   out  player 2 right held (E0 74, right arrow)
//   code        out  last good scan byte
//   code_valid  out  one-cycle strobe, code updated
//   frame_err   out  one-cycle strobe, frame rejected
//
// Build option
//   PS2_PARITY_CHECK_EN  enables odd-parity checking in ps2_frame_rx.
// -----------------------------------------------------------------------------
module ps2_paddle_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       to_left1,
  output logic       to_right1,
  output logic       to_left2,
  output logic       to_right2,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .mclk     (mclk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (code),
    .rx_valid (code_valid),
    .rx_err   (frame_err)
  );

  // ---------------------------------------------------------------------------
  // Prefix decoder and key registers
  // ---------------------------------------------------------------------------
  logic       ext;
  logic       brk;
  logic [3:0] keys;    // indexed by key_e
  key_map_t   hit_map;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path through them leaves a value unassigned and no latch is inferred.
  always_comb begin
    hit_map = '0;
    hit_map = map_key(ext, code);
  end

  // Prefixes accumulate until a non-prefix byte arrives; that byte consumes
  // them whether or not it is a game key. Rejected frames never raise
  // code_valid, so they leave the prefixes and keys alone. A make of an
  // already-held key (typematic repeat) simply rewrites a 1.
  always_ff @(posedge mclk) begin
    if (!rst) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      keys <= '0;
    end else if (code_valid) begin
      if (code == SC_EXT) begin
        ext <= 1'b1;
      end else if (code == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        if (hit_map.hit) begin
          keys[hit_map.key] <= ~brk;
        end
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign to_left1  = keys[KEY_LEFT1];
  assign to_right1 = keys[KEY_RIGHT1];
  assign to_left2  = keys[KEY_LEFT2];
  assign to_right2 = keys[KEY_RIGHT2];

endmodule

// File: tb/tb_ps2_paddle_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_paddle_rx
// Directed bench for ps2_paddle_rx. PS/2 frames are bit-banged on the
// negative mclk edge; outputs are sampled on the negative edge as well.
// Key state is shown as {to_right2, to_left2, to_right1, to_left1}.
// -----------------------------------------------------------------------------
module tb_ps2_paddle_rx;

  localparam int TO   = 300;  // shortened timeout for simulation
  localparam int HALF = 8;    // mclk cycles per PS/2 clock half-period

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       to_left1, to_right1, to_left2, to_right2;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  ps2_paddle_rx #(
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TO)
  ) dut (
    .mclk       (mclk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .to_left1   (to_left1),
    .to_right1  (to_right1),
    .to_left2   (to_left2),
    .to_right2  (to_right2),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  // Strobe counters
  always @(negedge mclk) begin
    if (code_valid) n_valid++;
    if (frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keys_now();
    return {to_right2, to_left2, to_right1, to_left1};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge mclk);
    ps2_data = b;
    repeat (HALF) @(negedge mclk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge mclk);
    ps2_clk = 1'b1;
  endtask

  // Full frame. stop_bit drives the stop bit, flip_par turns the correct odd
  // parity bit into an even one, timed checks strobe/key latency on the stop fall.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic flip_par, input logic timed);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    if (!timed) begin
      send_bit(stop_bit);
    end else begin
      @(negedge mclk);
      ps2_data = stop_bit;
      repeat (HALF) @(negedge mclk);
      ps2_clk = 1'b0;                      // stop-bit fall driven here
      @(negedge mclk);
      check("lat valid n1", code_valid, 1'b0);
      @(negedge mclk);
      check("lat valid n2", code_valid, 1'b0);
      @(negedge mclk);
      check("lat valid n3", code_valid, 1'b1);
      check("lat code n3", code, b);
      check("lat key n3", to_left1, 1'b0);
      @(negedge mclk);
      check("lat valid n4", code_valid, 1'b0);
      check("lat key n4", to_left1, 1'b1);
      repeat (HALF - 4) @(negedge mclk);
      ps2_clk = 1'b1;
    end
    repeat (6) @(negedge mclk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (4) @(negedge mclk);
    check("rst keys", keys_now(), 4'b0000);
    check("rst code", code, 8'h00);
    check("rst valid", code_valid, 1'b0);
    check("rst err", frame_err, 1'b0);
    rst = 1'b1;
    repeat (4) @(negedge mclk);
    check("idle no strobes", n_valid + n_err, 0);

    // ---------------- 1: A make ----------------
    send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
    check("t1 nvalid", n_valid, 1);
    check("t1 code", code, 8'h1C);
    check("t1 keys", keys_now(), 4'b0001);

    // ---------------- 2: A break ----------------
    good(8'hF0);
    check("t2 F0 alone keys", keys_now(), 4'b0001);
    check("t2 F0 code", code, 8'hF0);
    good(8'h1C);
    check("t2 break keys", keys_now(), 4'b0000);
    check("t2 nvalid", n_valid, 3);

    // ---------------- 3: right arrow ----------------
    good(8'hE0); good(8'h74);
    check("t3 E0 74 keys", keys_now(), 4'b1000);
    good(8'h74);
    check("t3 keypad6 keys", keys_now(), 4'b1000);
    good(8'hE0); good(8'hF0); good(8'h74);
    check("t3 release keys", keys_now(), 4'b0000);
    check("t3 nvalid", n_valid, 9);

    // both player-1 keys held, typematic repeat, left arrow
    good(8'h1C); good(8'h23);
    check("both held", keys_now(), 4'b0011);
    good(8'h1C);
    check("typematic", keys_now(), 4'b0011);
    good(8'hE0); good(8'h6B);
    check("left arrow", keys_now(), 4'b0111);

    // ---------------- 4: bad stop bit ----------------
    good(8'hF0);                                  // brk pending across the error
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("t4 nerr", n_err, 1);
    check("t4 code kept", code, 8'hF0);
    check("t4 keys kept", keys_now(), 4'b0111);
    good(8'h1C);                                  // pending F0 still applies
    check("t4 brk kept keys", keys_now(), 4'b0110);
    check("t4 nvalid", n_valid, 16);

    good(8'hF0); good(8'h23);
    check("D release", keys_now(), 4'b0100);
    good(8'hE0); good(8'hF0); good(8'h6B);
    check("larrow release", keys_now(), 4'b0000);
    check("pre t5 code", code, 8'h6B);

    // ---------------- 5: even parity ----------------
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("t5 nerr", n_err, 2);
    check("t5 code", code, 8'h6B);
    check("t5 keys", keys_now(), 4'b0000);
    check("t5 nvalid", n_valid, 21);
`else
    check("t5 nerr", n_err, 1);
    check("t5 code", code, 8'h1C);
    check("t5 keys", keys_now(), 4'b0001);
    check("t5 nvalid", n_valid, 22);
`endif

    // ---------------- 6: timeout ----------------
    begin : t6
      int e0, v0;
      logic [7:0] c0;
      logic [3:0] k0;
      e0 = n_err; v0 = n_valid; c0 = code; k0 = keys_now();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);   // partial byte, clock stops high
      repeat (TO / 2) @(negedge mclk);
      check("t6 no early err", n_err, e0);
      repeat (TO) @(negedge mclk);
      check("t6 timeout err", n_err, e0 + 1);
      check("t6 no valid", n_valid, v0);
      check("t6 code kept", code, c0);
      check("t6 keys kept", keys_now(), k0);
      good(8'h23);
      check("t6 recover keys", keys_now(), k0 | 4'b0010);
      check("t6 recover code", code, 8'h23);
      check("t6 recover nvalid", n_valid, v0 + 1);
    end

    // ---------------- reset mid-frame ----------------
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    check("midrst keys", keys_now(), 4'b0000);
    check("midrst code", code, 8'h00);
    check("midrst valid", code_valid, 1'b0);
    check("midrst err", frame_err, 1'b0);
    ps2_data = 1'b1;
    repeat (3) @(negedge mclk);
    rst = 1'b1;
    repeat (4) @(negedge mclk);
    good(8'h1C);
    check("post rst keys", keys_now(), 4'b0001);
    check("post rst code", code, 8'h1C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
